// File: rtl/blinker_pkg.sv
// Shared types and constants for the LED blinker.
package blinker_pkg;

  typedef enum logic {BLINK, RUN} mode_e;
  typedef enum logic {LEFT, RIGHT} dir_e;

  localparam logic [7:0] RUN_SEED = 8'h01;

  function automatic logic [7:0] rotate_led(input logic [7:0] v, input dir_e dir);
    return (dir == LEFT) ? {v[6:0], v[7]} : {v[0], v[7:1]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a 1-cycle press pulse
// on each accepted 0->1 change of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any cycle where the synced level matches the stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_blinker.sv
// Board-level LED pattern generator: BLINK (all on/off) or RUN (rotating single LED),
// stepped by a tick counter and controlled by three debounced push buttons.
module led_blinker
  import blinker_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_CYCLES     = CLK_HZ / 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk_p,
  input  logic       clk_n,
  input  logic       rst,
  input  logic       sw_btn,
  input  logic       left_btn,
  input  logic       right_btn,
  output logic [7:0] led
);

  localparam int TCW = $clog2(TICK_CYCLES);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_CYCLES - 1);

  logic clk;

`ifdef SYNTHESIS
  IBUFDS u_clk_ibuf (.I(clk_p), .IB(clk_n), .O(clk));
`else
  logic unused_clk_n;
  assign unused_clk_n = clk_n;
  assign clk = clk_p;
`endif

  logic sw_press, left_press, right_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk(clk), .rst(rst), .btn_i(sw_btn), .press_o(sw_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left_db (
    .clk(clk), .rst(rst), .btn_i(left_btn), .press_o(left_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right_db (
    .clk(clk), .rst(rst), .btn_i(right_btn), .press_o(right_press));

  mode_e          mode_q, mode_d;
  dir_e           dir_q, dir_d;
  logic [7:0]     led_q, led_d;
  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic           tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= BLINK;
      dir_q      <= LEFT;
      led_q      <= 8'h00;
      tick_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      led_q      <= led_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // A mode toggle restarts the tick period and swallows a coincident tick; the RUN
  // step uses the direction as updated in the same cycle.
  always_comb begin
    mode_d     = mode_q;
    dir_d      = dir_q;
    led_d      = led_q;
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    if (left_press && !right_press) begin
      dir_d = LEFT;
    end else if (right_press && !left_press) begin
      dir_d = RIGHT;
    end

    if (sw_press) begin
      tick_cnt_d = '0;
      if (mode_q == BLINK) begin
        mode_d = RUN;
        led_d  = RUN_SEED;
      end else begin
        mode_d = BLINK;
        led_d  = 8'h00;
      end
    end else if (tick) begin
      if (mode_q == BLINK) begin
        led_d = ~led_q;
      end else begin
        led_d = rotate_led(led_q, dir_d);
      end
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_blinker.sv
// Scoreboard bench for led_blinker: a cycle-level reference model pushes the expected
// LED value every clock and a monitor pops and compares on the opposite edge.
module tb_led_blinker;

  localparam int T = 8;
  localparam int D = 4;

  logic       clk_p = 1'b0;
  logic       clk_n;
  logic       rst = 1'b0;
  logic       sw_btn = 1'b0;
  logic       left_btn = 1'b0;
  logic       right_btn = 1'b0;
  logic [7:0] led;

  always #5 clk_p = ~clk_p;
  assign clk_n = ~clk_p;

  led_blinker #(
    .CLK_HZ(100_000_000),
    .TICK_CYCLES(T),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk_p(clk_p),
    .clk_n(clk_n),
    .rst(rst),
    .sw_btn(sw_btn),
    .left_btn(left_btn),
    .right_btn(right_btn),
    .led(led)
  );

  int         checks = 0;
  int         failures = 0;
  int         cycle = 0;
  logic [7:0] sbQ[$];

  // Reference model state: bit 0 = sw, bit 1 = left, bit 2 = right.
  bit         mValid = 1'b0;
  bit         mRun, mLeft, mBlinkOn;
  int         mPos, mTickCnt;
  logic [2:0] rawQ[$];
  logic [2:0] syncQ[$];
  logic [2:0] mStable, mPend;
  logic [7:0] mExpLed = 8'h00;

  always @(posedge clk_p) begin
    logic [2:0] raw, synced, pressNow;
    bit         tickNow, allDiff;
    raw = {right_btn, left_btn, sw_btn};
    if (rst) begin
      mValid = 1'b1; mRun = 1'b0; mLeft = 1'b1; mBlinkOn = 1'b0;
      mPos = 0; mTickCnt = 0; mStable = '0; mPend = '0;
      rawQ.delete(); rawQ.push_back(3'b000); rawQ.push_back(3'b000);
      syncQ.delete();
      mExpLed = 8'h00;
      sbQ.push_back(mExpLed);
    end else if (mValid) begin
      pressNow = mPend;
      synced = rawQ[rawQ.size() - 2];
      rawQ.push_back(raw);
      if (rawQ.size() > 4) void'(rawQ.pop_front());
      syncQ.push_back(synced);
      if (syncQ.size() > D) void'(syncQ.pop_front());
      mPend = '0;
      for (int b = 0; b < 3; b++) begin
        if (syncQ.size() == D) begin
          allDiff = 1'b1;
          foreach (syncQ[i]) if (syncQ[i][b] == mStable[b]) allDiff = 1'b0;
          if (allDiff) begin
            mStable[b] = ~mStable[b];
            mPend[b] = mStable[b];
          end
        end
      end
      tickNow = ((mTickCnt % T) == T - 1);
      if (pressNow[1] && !pressNow[2]) mLeft = 1'b1;
      else if (pressNow[2] && !pressNow[1]) mLeft = 1'b0;
      if (pressNow[0]) begin
        mRun = !mRun; mPos = 0; mBlinkOn = 1'b0; mTickCnt = 0;
      end else begin
        mTickCnt++;
        if (tickNow) begin
          if (mRun) mPos = mLeft ? (mPos + 1) % 8 : (mPos + 7) % 8;
          else mBlinkOn = !mBlinkOn;
        end
      end
      mExpLed = mRun ? 8'(1 << mPos) : (mBlinkOn ? 8'hFF : 8'h00);
      sbQ.push_back(mExpLed);
    end
  end

  always @(negedge clk_p) begin
    logic [7:0] exp;
    cycle++;
    if (sbQ.size() > 0) begin
      exp = sbQ.pop_front();
      checks++;
      if (led !== exp) begin
        failures++;
        $display("[TB] FAIL led_scoreboard cycle=%0d got=%02h exp=%02h", cycle, led, exp);
      end
    end
  end

  task automatic applyStimulus(input bit s, input bit l, input bit r, input bit rs, input int n);
    sw_btn = s; left_btn = l; right_btn = r; rst = rs;
    repeat (n) @(negedge clk_p);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp);
    checks++;
    if (led !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%02h exp=%02h", name, led, exp);
    end
  endtask

  task automatic waitForLed(input logic [7:0] target, input int budget);
    int i;
    for (i = 0; i < budget && mExpLed != target; i++) @(negedge clk_p);
    if (mExpLed != target) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_led timeout got=%02h exp=%02h", mExpLed, target);
    end
  endtask

  task automatic waitTickPhase(input int phase, input int budget);
    int i;
    for (i = 0; i < budget && (mTickCnt % T) != phase; i++) @(negedge clk_p);
    if ((mTickCnt % T) != phase) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_tick timeout got=%0d exp=%0d", mTickCnt % T, phase);
    end
  endtask

  initial begin
    repeat (10) @(negedge clk_p);
    applyStimulus(0, 0, 0, 1, 10);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("reset_led", 8'h00);
    applyStimulus(0, 0, 0, 0, 8);
    checkOutput("blink_tick1", 8'hFF);
    applyStimulus(0, 0, 0, 0, 8);
    checkOutput("blink_tick2", 8'h00);

    applyStimulus(1, 0, 0, 0, 7);
    checkOutput("sw_enter_run", 8'h01);
    applyStimulus(1, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 5);
    checkOutput("run_step_left", 8'h02);

    waitForLed(8'h04, 40);
    applyStimulus(0, 0, 1, 0, 8);
    checkOutput("right_step", 8'h02);
    applyStimulus(0, 0, 1, 0, 2);
    applyStimulus(0, 0, 0, 0, 6);
    checkOutput("right_step2", 8'h01);
    applyStimulus(0, 0, 0, 0, 8);
    checkOutput("right_wrap", 8'h80);

    applyStimulus(0, 1, 1, 0, 10);
    applyStimulus(0, 0, 0, 0, 30);

    for (int i = 0; i < 10; i++) applyStimulus(!sw_btn, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 20);

    waitTickPhase(1, 20);
    applyStimulus(1, 0, 0, 0, 7);
    checkOutput("sw_exit_coincident_tick", 8'h00);
    applyStimulus(1, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 5);
    checkOutput("blink_after_exit", 8'hFF);

    applyStimulus(1, 0, 0, 0, 10);
    applyStimulus(0, 0, 0, 0, 0);
    waitForLed(8'h10, 120);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mid_run_reset", 8'h00);
    applyStimulus(1, 0, 0, 0, 7);
    checkOutput("rerun_seed", 8'h01);
    applyStimulus(1, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 5);
    checkOutput("dir_left_after_reset", 8'h02);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0,
                    $urandom_range(1, 12));
    end
    applyStimulus(0, 0, 0, 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout at cycle=%0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
